// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock AXI4-Stream FIFO with first-word-fall-through output.
// Stores the full beat (tdata/tstrb/tkeep/tlast/tid/tdest/tuser), reports the fill
// level and provides programmable almost-full / almost-empty flags.
// Optional store-and-forward frame mode: define AXIS_FIFO_FRAME_EN.
//   Defined  : m_axis_tvalid only when a complete frame is held, or the FIFO is full
//              (long packets are then forwarded cut-through to avoid deadlock).
//   Undefined: m_axis_tvalid whenever the FIFO holds at least one beat.
module axis_sync_fifo #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ID_W      = 1,
  parameter int unsigned DEST_W    = 1,
  parameter int unsigned USER_W    = 1,
  parameter int unsigned AFULL_TH  = DEPTH - 4,
  parameter int unsigned AEMPTY_TH = 4,
  localparam int unsigned DATA_BW  = DATA_W / 8,
  localparam int unsigned LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [DATA_BW-1:0] s_axis_tstrb,
  input  logic [DATA_BW-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic [ID_W-1:0]   s_axis_tid,
  input  logic [DEST_W-1:0] s_axis_tdest,
  input  logic [USER_W-1:0] s_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [DATA_BW-1:0] m_axis_tstrb,
  output logic [DATA_BW-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [ID_W-1:0]   m_axis_tid,
  output logic [DEST_W-1:0] m_axis_tdest,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned BEAT_W = DATA_W + 2 * DATA_BW + 1 + ID_W + DEST_W + USER_W;

  logic [BEAT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LVL_W-1:0]  level_q, level_n;
  logic              tready_q, tvalid_q, tvalid_n;
  logic              afull_q, aempty_q;
  logic [BEAT_W-1:0] head_q, head_n, s_beat;
  logic              wr_en, rd_en;

`ifdef AXIS_FIFO_FRAME_EN
  logic [LVL_W-1:0]  frame_q, frame_n;
`endif

  assign s_beat = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                   s_axis_tid, s_axis_tdest, s_axis_tuser};

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
          m_axis_tid, m_axis_tdest, m_axis_tuser} = head_q;

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign level         = level_q;
  assign almost_full   = afull_q;
  assign almost_empty  = aempty_q;

  // Next-state: transfers, pointers, level, and the head entry seen after this edge.
  always_comb begin
    wr_en    = s_axis_tvalid & tready_q;
    rd_en    = tvalid_q & m_axis_tready;
    wr_ptr_n = wr_ptr + PTR_W'(wr_en);
    rd_ptr_n = rd_ptr + PTR_W'(rd_en);
    level_n  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    // The slot about to become head may be the one being written this cycle.
    head_n   = (wr_en && (wr_ptr == rd_ptr_n)) ? s_beat : mem[rd_ptr_n];
`ifdef AXIS_FIFO_FRAME_EN
    frame_n  = frame_q + LVL_W'(wr_en & s_axis_tlast) - LVL_W'(rd_en & m_axis_tlast);
    tvalid_n = (frame_n != '0) || (level_n == LVL_W'(DEPTH));
`else
    tvalid_n = (level_n != '0);
`endif
  end

  // Storage array: written only on an accepted beat, no reset needed.
  always_ff @(posedge axis_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_beat;
    end
  end

  // Control and output registers; reset forces the idle/empty view immediately.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      head_q   <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      level_q  <= level_n;
      tready_q <= (level_n < LVL_W'(DEPTH));
      tvalid_q <= tvalid_n;
      afull_q  <= (level_n >= LVL_W'(AFULL_TH));
      aempty_q <= (level_n <= LVL_W'(AEMPTY_TH));
      head_q   <= head_n;
    end
  end

`ifdef AXIS_FIFO_FRAME_EN
  // Count of complete frames currently held.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_n;
    end
  end
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Bench for axis_sync_fifo: queue-based reference model, per-cycle compare process,
// and directed tests with literal expectations.
module tb_axis_sync_fifo;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DATA_BW = 1;
  localparam int unsigned LVL_W   = 6;
  localparam int unsigned AFULL_TH  = DEPTH - 4;
  localparam int unsigned AEMPTY_TH = 4;
  localparam int unsigned BEAT_W  = 14;
  localparam int unsigned LAST_BIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tvalid = 1'b0, s_tready;
  logic [7:0] s_tdata = '0;
  logic s_tstrb = 1'b0, s_tkeep = 1'b0, s_tlast = 1'b0;
  logic s_tid = 1'b0, s_tdest = 1'b0, s_tuser = 1'b0;
  logic m_tvalid, m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser;
  logic [LVL_W-1:0] level;
  logic afull, aempty;

  int checks = 0;
  int errors = 0;

  axis_sync_fifo dut (
    .axis_clk(clk), .axis_rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser),
    .level(level), .almost_full(afull), .almost_empty(aempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BEAT_W-1:0] pack(input logic [7:0] d, input logic st,
      input logic kp, input logic lst, input logic id, input logic de, input logic us);
    return {d, st, kp, lst, id, de, us};
  endfunction

  // Reference model: a queue of stored beats plus a complete-frame count.
  logic [BEAT_W-1:0] mq[$];
  logic [BEAT_W-1:0] tmp_beat;
  int  mdl_frames = 0;
  bit  mdl_rdy = 1'b0;
  bit  mdl_w, mdl_r;

  function automatic bit mdl_valid();
`ifdef AXIS_FIFO_FRAME_EN
    return (mdl_frames > 0) || (mq.size() == DEPTH);
`else
    return mq.size() > 0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mdl_frames = 0;
      mdl_rdy = 1'b0;
    end else begin
      mdl_w = s_tvalid && mdl_rdy;
      mdl_r = mdl_valid() && m_tready;
      if (mdl_r) begin
        tmp_beat = mq.pop_front();
        if (tmp_beat[LAST_BIT]) mdl_frames--;
      end
      if (mdl_w) begin
        mq.push_back(pack(s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser));
        if (s_tlast) mdl_frames++;
      end
      mdl_rdy = (mq.size() < DEPTH);
    end
  end

  // Per-cycle compare against the model, stall stability, and capture of read beats.
  logic [BEAT_W-1:0] rx[$];
  logic [BEAT_W-1:0] dut_beat, prev_beat;
  bit prev_stall = 1'b0;
  bit lvl1_en = 1'b0;

  always @(negedge clk) begin
    dut_beat = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    chk("m_tvalid", 64'(m_tvalid), 64'(mdl_valid()));
    chk("s_tready", 64'(s_tready), 64'(mdl_rdy));
    chk("level", 64'(level), 64'(mq.size()));
    chk("almost_full", 64'(afull), 64'(mq.size() >= AFULL_TH));
    chk("almost_empty", 64'(aempty), 64'(mq.size() <= AEMPTY_TH));
    if (mdl_valid()) chk("m_beat", 64'(dut_beat), 64'(mq[0]));
    if (lvl1_en) chk("level_le1", 64'(level <= 1), 64'd1);
    if (prev_stall && !rst) chk("stall_hold", 64'(dut_beat), 64'(prev_beat));
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_beat  = dut_beat;
    if (m_tvalid && m_tready && !rst) rx.push_back(dut_beat);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic lst, input logic [4:0] sb);
    bit ok;
    int n;
    s_tvalid = 1'b1;
    s_tdata = d; s_tlast = lst;
    {s_tstrb, s_tkeep, s_tid, s_tdest, s_tuser} = sb;
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_tready;
      cyc();
      n++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  logic [BEAT_W-1:0] sent[$];
  bit tx_done;
  logic [7:0] rd;
  logic [4:0] rsb;
  logic rl;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_aempty", 64'(aempty), 64'd1);
    chk("rst_afull", 64'(afull), 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("tready_still_low", 64'(s_tready), 64'd0);
    cyc();
    @(negedge clk);
    chk("tready_rises", 64'(s_tready), 64'd1);
    cyc();

    // Fill 0..31 with the sink stalled
    m_tready = 1'b0;
    for (int i = 0; i < 32; i++) send(8'(i), i == 31, 5'b11000);
    @(negedge clk);
    chk("full_level", 64'(level), 64'd32);
    chk("full_tready", 64'(s_tready), 64'd0);
    chk("full_afull", 64'(afull), 64'd1);
    cyc();
    s_tvalid = 1'b1; s_tdata = 8'd32; s_tlast = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("beat33_blocked", 64'(s_tready), 64'd0);
      chk("beat33_level", 64'(level), 64'd32);
    end
    cyc();
    s_tvalid = 1'b0;

    // Drain in order, one beat per cycle
    rx.delete();
    m_tready = 1'b1;
    repeat (32) cyc();
    @(negedge clk);
    chk("drain_count", 64'(rx.size()), 64'd32);
    for (int i = 0; i < 32 && i < rx.size(); i++) begin
      tmp_beat = rx[i];
      chk("drain_data", 64'(tmp_beat[13:6]), 64'(i));
    end
    chk("drain_tvalid", 64'(m_tvalid), 64'd0);
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_aempty", 64'(aempty), 64'd1);
    cyc();

    // 64 beats streaming through with the sink always ready
    rx.delete();
    lvl1_en = 1'b1;
    for (int i = 0; i < 64; i++) send(8'(i % 256), 1'b1, 5'(i));
    repeat (3) cyc();
    lvl1_en = 1'b0;
    chk("stream_count", 64'(rx.size()), 64'd64);
    for (int i = 0; i < 64 && i < rx.size(); i++) begin
      tmp_beat = rx[i];
      chk("stream_data", 64'(tmp_beat[13:6]), 64'(i % 256));
    end

    // Random valid/ready with varied sideband
    rx.delete();
    sent.delete();
    tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(1, 0) == 1) cyc();
          rd = 8'($urandom);
          rsb = 5'($urandom);
          rl = (i == 999) ? 1'b1 : 1'($urandom);
          sent.push_back({rd, rsb[4], rsb[3], rl, rsb[2], rsb[1], rsb[0]});
          send(rd, rl, rsb);
        end
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          cyc();
          m_tready = 1'($urandom);
        end
      end
    join
    m_tready = 1'b1;
    for (int n = 0; n < 100 && mq.size() != 0; n++) cyc();
    repeat (2) cyc();
    chk("rand_count", 64'(rx.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < rx.size(); i++)
      chk("rand_beat", 64'(rx[i]), 64'(sent[i]));

    // Reset mid-stream with 10 entries held
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'h10 + i), 1'b0, 5'b00101);
    @(negedge clk);
    chk("pre_rst_level", 64'(level), 64'd10);
    cyc();
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_tready", 64'(s_tready), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    rx.delete();
    m_tready = 1'b1;
    send(8'hA5, 1'b1, 5'b11111);
    repeat (3) cyc();
    chk("post_rst_count", 64'(rx.size()), 64'd1);
    if (rx.size() > 0) begin
      tmp_beat = rx[0];
      chk("post_rst_data", 64'(tmp_beat[13:6]), 64'hA5);
    end

`ifdef AXIS_FIFO_FRAME_EN
    // Store-and-forward: held until tlast is accepted
    rx.delete();
    for (int i = 0; i < 5; i++) begin
      send(8'(i), i == 4, 5'b11000);
      @(negedge clk);
      chk("frame_tvalid", 64'(m_tvalid), (i == 4) ? 64'd1 : 64'd0);
      cyc();
    end
    repeat (8) cyc();
    chk("frame_count", 64'(rx.size()), 64'd5);

    // Oversized packet forwards once full
    rx.delete();
    for (int i = 0; i < 40; i++) send(8'(i), 1'b0, 5'b11000);
    chk("long_started", 64'(rx.size() > 0), 64'd1);
    if (rx.size() > 0) begin
      tmp_beat = rx[0];
      chk("long_first", 64'(tmp_beat[13:6]), 64'd0);
    end
    send(8'd40, 1'b1, 5'b11000);
    repeat (40) cyc();
    chk("long_count", 64'(rx.size()), 64'd41);
    if (rx.size() == 41) begin
      tmp_beat = rx[40];
      chk("long_last", 64'(tmp_beat[13:6]), 64'd40);
    end
`endif

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
